mat_unit: RTL and testbench

- Weight-stationary N×N systolic matrix-multiply array; single-precision floating point.
- Weights are streamed in through the same row inputs used for data, under control of load_weight and weight_progress.
- Activations enter skewed on the left (one row per data_in lane) and move right; partial sums move down.
- Column results exit the bottom row as data_out, also skewed.

---
 rtl/mat_unit.sv | 187 ++++++++++++++++++
 tb/tb_mat_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mat_unit.sv
// mat_unit: weight-stationary N x N systolic matrix-multiply array.
// Activations flow right, partial sums flow down, and weights are latched
// row by row from the same data_in lanes during the load phase.
// Values are IEEE-754 single precision carried as 32-bit vectors. Denormals
// flush to zero and rounding is round-to-nearest-even. Inf/NaN operands
// saturate to a signed infinity.
module mat_unit #(
  parameter int N = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       load_weight,
  input  logic [$clog2(2*N)-1:0]     weight_progress,
  input  logic [N-1:0][31:0]         data_in,
  output logic [N-1:0][31:0]         data_out
);

  localparam int PW = $clog2(2*N);

  // Single-precision multiply.
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [47:0] prod;
    logic [9:0]  e;
    logic [22:0] m;
    logic [23:0] mr;
    logic        g;
    logic        st;
    s    = a[31] ^ b[31];
    prod = '0;
    e    = '0;
    m    = '0;
    mr   = '0;
    g    = 1'b0;
    st   = 1'b0;
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
    if (a[30:23] == 8'hff || b[30:23] == 8'hff) return {s, 8'hff, 23'd0};
    prod = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e    = {2'b00, a[30:23]} + {2'b00, b[30:23]};
    if (prod[47]) begin
      m  = prod[46:24];
      g  = prod[23];
      st = |prod[22:0];
      e  = e + 10'd1;
    end else begin
      m  = prod[45:23];
      g  = prod[22];
      st = |prod[21:0];
    end
    if (g && (st || m[0])) begin
      mr = {1'b0, m} + 24'd1;
      if (mr[23]) begin
        m = 23'd0;
        e = e + 10'd1;
      end else begin
        m = mr[22:0];
      end
    end
    if (e <= 10'd127) return {s, 31'd0};
    if (e >= 10'd382) return {s, 8'hff, 23'd0};
    e = e - 10'd127;
    return {s, e[7:0], m};
  endfunction

  // Single-precision add. Operands are ordered by magnitude, the smaller is
  // aligned with a sticky bit, and the result is renormalised and rounded.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x;
    logic [31:0] y;
    logic [7:0]  d;
    logic [26:0] mx;
    logic [26:0] my;
    logic [26:0] sum;
    logic [26:0] mask;
    logic [27:0] wsum;
    logic [9:0]  e;
    logic [23:0] mr;
    logic [22:0] m;
    x = a; y = b; d = '0; mx = '0; my = '0; sum = '0; mask = '0;
    wsum = '0; e = '0; mr = '0; m = '0;
    if (a[30:23] == 8'd0) return (b[30:23] == 8'd0) ? {a[31] & b[31], 31'd0} : b;
    if (b[30:23] == 8'd0) return a;
    if (a[30:23] == 8'hff) return a;
    if (b[30:23] == 8'hff) return b;
    if (a[30:0] < b[30:0]) begin
      x = b;
      y = a;
    end
    d  = x[30:23] - y[30:23];
    mx = {1'b1, x[22:0], 3'b000};
    my = {1'b1, y[22:0], 3'b000};
    if (d >= 8'd27) begin
      my = 27'd1;
    end else begin
      mask = (27'd1 << d) - 27'd1;
      my   = (my >> d) | {26'd0, |(my & mask)};
    end
    e = {2'b00, x[30:23]};
    if (x[31] == y[31]) begin
      wsum = {1'b0, mx} + {1'b0, my};
      if (wsum[27]) begin
        sum = wsum[27:1] | {26'd0, wsum[0]};
        e   = e + 10'd1;
      end else begin
        sum = wsum[26:0];
      end
    end else begin
      sum = mx - my;
      if (sum == 27'd0) return 32'd0;
      for (int i = 0; i < 26; i++) begin
        if (!sum[26]) begin
          sum = sum << 1;
          e   = e - 10'd1;
        end
      end
    end
    m = sum[25:3];
    if (sum[2] && (sum[3] || sum[1] || sum[0])) begin
      mr = {1'b0, sum[25:3]} + 24'd1;
      if (mr[23]) begin
        m = 23'd0;
        e = e + 10'd1;
      end else begin
        m = mr[22:0];
      end
    end
    if (e == 10'd0 || e[9]) return {x[31], 31'd0};
    if (e >= 10'd255) return {x[31], 8'hff, 23'd0};
    return {x[31], e[7:0], m};
  endfunction

  logic [31:0] x_arr [N][N];
  logic [31:0] p_arr [N][N];

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      logic [31:0] xin;
      logic [31:0] pin;
      logic [31:0] x_q, x_d;
      logic [31:0] w_q, w_d;
      logic [31:0] p_q, p_d;

      if (gj == 0) begin : g_xin_edge
        assign xin = data_in[gi];
      end else begin : g_xin_inner
        assign xin = x_arr[gi][gj-1];
      end

      if (gi == 0) begin : g_pin_edge
        assign pin = 32'd0;
      end else begin : g_pin_inner
        assign pin = p_arr[gi-1][gj];
      end

      // Next-state: forward activation, accumulate with the held weight, latch on this row's step.
      always_comb begin
        x_d = xin;
        p_d = fp_add(pin, fp_mul(w_q, xin));
        w_d = w_q;
        if (load_weight && weight_progress == PW'(gi + N)) begin
          w_d = xin;
        end
      end

      // PE state registers; reset discards weights and in-flight sums.
      always_ff @(posedge clock) begin
        if (!reset_n) begin
          x_q <= 32'd0;
          w_q <= 32'd0;
          p_q <= 32'd0;
        end else begin
          x_q <= x_d;
          w_q <= w_d;
          p_q <= p_d;
        end
      end

      assign x_arr[gi][gj] = x_q;
      assign p_arr[gi][gj] = p_q;
    end
  end

  for (genvar gj = 0; gj < N; gj++) begin : g_out
    assign data_out[gj] = p_arr[N-1][gj];
  end

endmodule

// File: tb/tb_mat_unit.sv
// tb_mat_unit: randomized and directed checks of mat_unit against a
// matrix-level reference (expected column j = sum over rows of W[r][j]*x[r]).
module tb_mat_unit;
  localparam int N    = 4;
  localparam int PW   = $clog2(2*N);
  localparam int MAXC = 48;

  logic                 clock = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 load_weight = 1'b0;
  logic [PW-1:0]        weight_progress = '0;
  logic [N-1:0][31:0]   data_in = '0;
  logic [N-1:0][31:0]   data_out;

  mat_unit #(.N(N)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .load_weight     (load_weight),
    .weight_progress (weight_progress),
    .data_in         (data_in),
    .data_out        (data_out)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Per-cycle stimulus plan for one test.
  bit rst_p  [MAXC];
  bit ld_p   [MAXC];
  int prog_p [MAXC];
  bit hx     [MAXC][N];
  int xv     [MAXC][N];

  int wt [N][N];   // weights the next load will program
  int mw [N][N];   // weights the array currently holds

  typedef struct { int cyc; int col; int expv; } chk_t;
  chk_t  chks[$];
  string test_name;

  // Integer to single-precision bit pattern (exact for |v| < 2^24).
  function automatic logic [31:0] i2f(input int v);
    logic [31:0] a;
    logic [31:0] sh;
    int          msb;
    if (v == 0) return 32'd0;
    a   = (v < 0) ? 32'(-v) : 32'(v);
    msb = 0;
    for (int i = 0; i < 31; i++) if (a[i]) msb = i;
    sh = a << (23 - msb);
    return {(v < 0), 8'(127 + msb), sh[22:0]};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic plan_zero(input int c);
    for (int j = 0; j < N; j++) chks.push_back('{c, j, 0});
  endtask

  task automatic clear_plan(input string name);
    test_name = name;
    for (int c = 0; c < MAXC; c++) begin
      rst_p[c] = 0; ld_p[c] = 0; prog_p[c] = 0;
      for (int r = 0; r < N; r++) begin hx[c][r] = 0; xv[c][r] = 0; end
    end
    for (int r = 0; r < N; r++) for (int j = 0; j < N; j++) mw[r][j] = 0;
    chks.delete();
    rst_p[0] = 1;
    plan_zero(0);
  endtask

  // Controller load sequence: w(r,j) is sent on row r at progress r+N-j.
  task automatic plan_load(input int start);
    for (int p = 0; p < 2*N; p++) begin
      ld_p[start+p]   = 1;
      prog_p[start+p] = p;
      for (int r = 0; r < N; r++) begin
        int j;
        j = r + N - p;
        if (j >= 0 && j < N) begin
          hx[start+p][r] = 1;
          xv[start+p][r] = wt[r][j];
        end
      end
    end
    for (int r = 0; r < N; r++) for (int j = 0; j < N; j++) mw[r][j] = wt[r][j];
  endtask

  // Skewed activation vector starting at cycle s; results expected before 'kill'.
  task automatic plan_vec(input int s, input int v[N], input int kill);
    for (int r = 0; r < N; r++) begin
      hx[s+r][r] = 1;
      xv[s+r][r] = v[r];
    end
    for (int j = 0; j < N; j++) begin
      int e;
      e = 0;
      for (int r = 0; r < N; r++) e += mw[r][j] * v[r];
      if (s + j + N - 1 < kill) chks.push_back('{s + j + N - 1, j, e});
    end
  endtask

  task automatic run(input int len);
    for (int c = 0; c < len; c++) begin
      reset_n         = !rst_p[c];
      load_weight     = ld_p[c];
      weight_progress = PW'(prog_p[c]);
      for (int r = 0; r < N; r++)
        data_in[r] = i2f(hx[c][r] ? xv[c][r] : int'($urandom_range(9, 1)));
      @(posedge clock);
      #1;
      foreach (chks[i]) begin
        if (chks[i].cyc == c) begin
          $display("%s c=%0d col=%0d got=%h exp=%h", test_name, c, chks[i].col,
                   data_out[chks[i].col], i2f(chks[i].expv));
          check_val($sformatf("%s_c%0d_col%0d", test_name, c, chks[i].col),
                    data_out[chks[i].col], i2f(chks[i].expv));
        end
      end
    end
  endtask

  int v[N];

  initial begin
    // All-ones weights, loaded while 5.0 vectors already stream in.
    clear_plan("ones");
    for (int r = 0; r < N; r++) for (int j = 0; j < N; j++) wt[r][j] = 1;
    plan_load(1);
    v = '{5, 5, 5, 5};
    for (int s = 6; s <= 9; s++) plan_vec(s, v, MAXC);
    run(17);

    // Row-dependent weights w(r,j) = r+1.
    clear_plan("rowweights");
    for (int r = 0; r < N; r++) for (int j = 0; j < N; j++) wt[r][j] = r + 1;
    plan_load(1);
    v = '{1, 2, 3, 4};
    plan_vec(6, v, MAXC);
    run(13);

    // Random signed weights and back-to-back random vectors.
    clear_plan("random");
    for (int r = 0; r < N; r++) for (int j = 0; j < N; j++) wt[r][j] = int'($urandom_range(8)) - 4;
    plan_load(1);
    for (int s = 6; s <= 11; s++) begin
      for (int r = 0; r < N; r++) v[r] = int'($urandom_range(16)) - 8;
      plan_vec(s, v, MAXC);
    end
    run(20);

    // Weights hold while progress cycles with load_weight low.
    clear_plan("hold");
    for (int r = 0; r < N; r++) for (int j = 0; j < N; j++) wt[r][j] = 1;
    plan_load(1);
    for (int c = 9; c <= 16; c++) prog_p[c] = c - 9;
    v = '{5, 5, 5, 5};
    plan_vec(17, v, MAXC);
    run(25);

    // Progress below N never latches.
    clear_plan("inert");
    for (int p = 0; p < N; p++) begin ld_p[1+p] = 1; prog_p[1+p] = p; end
    v = '{1, 2, 3, 4};
    plan_vec(6, v, MAXC);
    run(13);

    // Reset while results are streaming clears everything.
    clear_plan("midreset");
    for (int r = 0; r < N; r++) for (int j = 0; j < N; j++) wt[r][j] = 1;
    plan_load(1);
    v = '{5, 5, 5, 5};
    for (int s = 6; s <= 13; s++) plan_vec(s, v, 14);
    for (int r = 0; r < N; r++) for (int j = 0; j < N; j++) mw[r][j] = 0;
    rst_p[14] = 1;
    plan_zero(14);
    plan_vec(15, v, MAXC);
    plan_vec(16, v, MAXC);
    run(24);

    // Only column 2 carries weight.
    clear_plan("onecol");
    for (int r = 0; r < N; r++) for (int j = 0; j < N; j++) wt[r][j] = (j == 2) ? 1 : 0;
    plan_load(1);
    v = '{1, 2, 3, 4};
    plan_vec(6, v, MAXC);
    run(13);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
